// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: RoB id width, producer encodings and the round-robin pick.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  // Returns the producer that wins this cycle; only meaningful when a candidate exists.
  function automatic logic pick_src(input logic alu_cand, input logic lsb_cand,
                                    input logic last_grant);
    if (alu_cand && lsb_cand) return (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
    return lsb_cand ? SRC_LSB : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-producer result FIFO; pushes while full are dropped, flush empties it in one edge.
module cdb_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between the ALU and LSB, with per-source
// buffering, empty-FIFO bypass and a registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W   = ROB_SIZE_WIDTH,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_full,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_full,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value
);

  localparam int PW = ROB_ID_W + DATA_W;

  logic [PW-1:0]       alu_dout, lsb_dout, alu_cand_data, lsb_cand_data, win_data;
  logic                alu_empty, lsb_empty, alu_cand, lsb_cand, grant_any, grant_src;
  logic                act, flush, alu_push, alu_pop, lsb_push, lsb_pop;
  logic                cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_value_q, cdb_value_d;
  logic                last_grant_q, last_grant_d;

  assign act   = rdy && !clear;
  assign flush = rdy && clear;

  // An empty FIFO lets the incoming result compete directly (bypass).
  assign alu_cand      = !alu_empty || alu_valid;
  assign lsb_cand      = !lsb_empty || lsb_valid;
  assign alu_cand_data = alu_empty ? {alu_rob_id, alu_value} : alu_dout;
  assign lsb_cand_data = lsb_empty ? {lsb_rob_id, lsb_value} : lsb_dout;
  assign grant_any     = alu_cand || lsb_cand;
  assign grant_src     = pick_src(alu_cand, lsb_cand, last_grant_q);
  assign win_data      = (grant_src == SRC_LSB) ? lsb_cand_data : alu_cand_data;

  assign alu_pop  = act && grant_any && (grant_src == SRC_ALU) && !alu_empty;
  assign lsb_pop  = act && grant_any && (grant_src == SRC_LSB) && !lsb_empty;
  assign alu_push = act && alu_valid && !(grant_src == SRC_ALU && alu_empty);
  assign lsb_push = act && lsb_valid && !(grant_src == SRC_LSB && lsb_empty);

  cdb_fifo #(.DATA_W(PW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .push(alu_push), .pop(alu_pop), .flush(flush),
    .din({alu_rob_id, alu_value}), .dout(alu_dout), .empty(alu_empty), .full(alu_full)
  );

  cdb_fifo #(.DATA_W(PW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst_n(rst_n), .push(lsb_push), .pop(lsb_pop), .flush(flush),
    .din({lsb_rob_id, lsb_value}), .dout(lsb_dout), .empty(lsb_empty), .full(lsb_full)
  );

  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      cdb_valid_d  = 1'b0;
      last_grant_d = SRC_LSB;
    end else if (act) begin
      cdb_valid_d = grant_any;
      if (grant_any) begin
        {cdb_rob_id_d, cdb_value_d} = win_data;
        last_grant_d                = grant_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      last_grant_q <= SRC_LSB;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;

  // Producers must respect the full flags; a push while full is silently dropped.
  always @(posedge clk) begin
    if (rst_n && rdy) begin
      assert (!(alu_valid && alu_full));
      assert (!(lsb_valid && lsb_full));
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random checks of cdb_arbiter against a queue-based model of the CDB rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int RW    = ROB_SIZE_WIDTH;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [RW-1:0] id;
    logic [DW-1:0] v;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n, rdy, clear;
  logic          alu_valid, lsb_valid, alu_full, lsb_full;
  logic [RW-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
  logic [DW-1:0] alu_value, lsb_value, cdb_value;
  logic          cdb_valid;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_ID_W(RW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_full(alu_full),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
  );

  int n_cmp = 0;
  int n_bad = 0;

  res_t          aq[$];
  res_t          lq[$];
  bit            m_last_lsb;
  bit            m_valid;
  logic [RW-1:0] m_id;
  logic [DW-1:0] m_val;
  bit            saw_lsb_full;
  int            lsb_seq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_last_lsb = 1'b1;
    m_valid    = 1'b0;
    m_id       = '0;
    m_val      = '0;
  endtask

  // Drive one cycle of inputs, advance the model by the CDB rules, then compare after the edge.
  task automatic cycle(input bit r, input bit c, input bit av, input res_t a,
                       input bit lv, input res_t l);
    bit   ah, lh, take_lsb, a_used, l_used;
    res_t w;
    rdy = r; clear = c;
    alu_valid = av; alu_rob_id = a.id; alu_value = a.v;
    lsb_valid = lv; lsb_rob_id = l.id; lsb_value = l.v;
    a_used = 0; l_used = 0;
    if (r && c) begin
      aq.delete();
      lq.delete();
      m_valid    = 0;
      m_last_lsb = 1;
    end else if (r) begin
      ah = (aq.size() > 0) || av;
      lh = (lq.size() > 0) || lv;
      take_lsb = (ah && lh) ? !m_last_lsb : lh;
      if (!ah && !lh) m_valid = 0;
      else begin
        if (take_lsb) begin
          if (lq.size() > 0) w = lq.pop_front();
          else begin w = l; l_used = 1; end
        end else begin
          if (aq.size() > 0) w = aq.pop_front();
          else begin w = a; a_used = 1; end
        end
        m_valid    = 1;
        m_id       = w.id;
        m_val      = w.v;
        m_last_lsb = take_lsb;
      end
      if (av && !a_used) aq.push_back(a);
      if (lv && !l_used) lq.push_back(l);
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
    chk("cdb_value", 64'(cdb_value), 64'(m_val));
    chk("alu_full", 64'(alu_full), 64'(aq.size() == DEPTH));
    chk("lsb_full", 64'(lsb_full), 64'(lq.size() == DEPTH));
    if (lsb_full) saw_lsb_full = 1;
  endtask

  function automatic res_t rnd_res();
    res_t x;
    x.id = RW'($urandom);
    x.v  = $urandom;
    return x;
  endfunction

  task automatic idle();
    cycle(1, 0, 0, '0, 0, '0);
  endtask

  // Random cycle; producers only assert valid when their FIFO is not full.
  task automatic rnd_cycle(input int pa, input int pl, input int prdy, input int pclr);
    bit r, c, av, lv;
    res_t a, l;
    r  = $urandom_range(99) < prdy;
    c  = $urandom_range(99) < pclr;
    av = ($urandom_range(99) < pa) && (aq.size() < DEPTH);
    lv = ($urandom_range(99) < pl) && (lq.size() < DEPTH);
    a  = rnd_res();
    l  = rnd_res();
    l.id = RW'(lsb_seq);
    if (lv && r && !c) lsb_seq++;
    cycle(r, c, av, a, lv, l);
  endtask

  task automatic async_reset_pulse();
    rst_n = 0;
    #2;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    saw_lsb_full = 0;
    lsb_seq = 0;
    rst_n = 0; rdy = 0; clear = 0;
    alu_valid = 0; alu_rob_id = '0; alu_value = '0;
    lsb_valid = 0; lsb_rob_id = '0; lsb_value = '0;
    model_reset();
    #12;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_alu_full", 64'(alu_full), 64'd0);
    chk("rst_lsb_full", 64'(lsb_full), 64'd0);
    rst_n = 1;

    // Bypass of a lone ALU result.
    cycle(1, 0, 1, '{id: 4'd3, v: 32'h1234}, 0, '0);
    chk("byp_valid", 64'(cdb_valid), 64'd1);
    chk("byp_id", 64'(cdb_rob_id), 64'd3);
    chk("byp_value", 64'(cdb_value), 64'h1234);
    idle();
    chk("byp_drop", 64'(cdb_valid), 64'd0);

    // Tie right after reset: ALU first, LSB next cycle.
    async_reset_pulse();
    cycle(1, 0, 1, '{id: 4'd1, v: 32'hA}, 1, '{id: 4'd2, v: 32'hB});
    chk("tie_first_id", 64'(cdb_rob_id), 64'd1);
    idle();
    chk("tie_second_id", 64'(cdb_rob_id), 64'd2);
    chk("tie_second_val", 64'(cdb_value), 64'hB);
    idle();

    // Continuous contention until the LSB FIFO fills, then drain.
    lsb_seq = 0;
    for (int i = 0; i < 16; i++) rnd_cycle(100, 100, 100, 0);
    chk("lsb_full_rose", 64'(saw_lsb_full), 64'd1);

    // Freeze while a broadcast is live.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, rnd_res(), 0, rnd_res());
    chk("freeze_valid", 64'(cdb_valid), 64'd1);
    for (int i = 0; i < 12; i++) idle();

    // Buffer a few results, flush, then a fresh ALU result goes straight through.
    for (int i = 0; i < 5; i++) rnd_cycle(100, 100, 100, 0);
    cycle(1, 1, 1, rnd_res(), 1, rnd_res());
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_alu_full", 64'(alu_full), 64'd0);
    chk("flush_lsb_full", 64'(lsb_full), 64'd0);
    idle();
    chk("flush_empty", 64'(cdb_valid), 64'd0);
    cycle(1, 0, 1, '{id: 4'd7, v: 32'h77}, 0, '0);
    chk("post_flush_id", 64'(cdb_rob_id), 64'd7);
    idle();
    chk("post_flush_alone", 64'(cdb_valid), 64'd0);

    // Asynchronous reset mid-run with buffered results.
    for (int i = 0; i < 6; i++) rnd_cycle(100, 100, 100, 0);
    rst_n = 0;
    #2;
    chk("async_valid", 64'(cdb_valid), 64'd0);
    chk("async_alu_full", 64'(alu_full), 64'd0);
    chk("async_lsb_full", 64'(lsb_full), 64'd0);
    chk("async_id", 64'(cdb_rob_id), 64'd0);
    #1;
    rst_n = 1;
    model_reset();
    idle();
    chk("after_rst_idle", 64'(cdb_valid), 64'd0);

    // Mixed random traffic with stalls and occasional flushes.
    for (int i = 0; i < 300; i++) rnd_cycle(70, 70, 85, 3);
    for (int i = 0; i < 200; i++) rnd_cycle(95, 95, 90, 1);
    for (int i = 0; i < 200; i++) rnd_cycle(30, 40, 70, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
